// File: rtl/noc_params.sv
// Router-wide NoC parameters and the output-port encoding shared by the
// input buffers and the virtual-channel allocator.
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// One-hot single-winner arbiter; round-robin with a registered pointer when
// VC_ALLOC_RR_EN is defined, otherwise a plain lowest-index priority encoder.
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] request_i,
    input  logic         enable_i,
    output logic [N-1:0] grant_o
);

`ifdef VC_ALLOC_RR_EN
    logic [N-1:0] ptr_q, ptr_d;
    logic [N-1:0] masked;

    // Prefer requesters at or above the pointer; wrap to the lowest one otherwise.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        masked  = request_i & ~(ptr_q - N'(1));
        if (enable_i) begin
            if (|masked) begin
                grant_o = masked & (~masked + N'(1));
            end else begin
                grant_o = request_i & (~request_i + N'(1));
            end
        end
        if (|grant_o) begin
            ptr_d = {grant_o[N-2:0], grant_o[N-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= N'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        grant_o = '0;
        if (enable_i) begin
            grant_o = request_i & (~request_i + N'(1));
        end
    end
`endif

endmodule

// File: rtl/vc_allocator.sv
// Router VC allocator: grants free downstream VCs to input VCs and tracks ownership.
// Arbitration policy per out port selected by VC_ALLOC_RR_EN (fixed priority if undefined).
module vc_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM = noc_params::PORT_NUM,
    parameter int VC_NUM   = noc_params::VC_NUM
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]                request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]                out_port_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]                release_i,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0]                grant_o,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0][$clog2(VC_NUM)-1:0] vc_new_o,
    output logic                                            error_o
);

    localparam int VSZ   = $clog2(VC_NUM);
    localparam int PSZ   = $clog2(PORT_NUM);
    localparam int N_REQ = PORT_NUM * VC_NUM;
    localparam int RW    = $clog2(N_REQ);

    logic [PORT_NUM-1:0][VC_NUM-1:0]          busy_q, busy_d;
    logic [PORT_NUM-1:0][VC_NUM-1:0][RW-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0]                         held_q, held_d;
    logic [N_REQ-1:0][PSZ-1:0]                held_port_q, held_port_d;
    logic [N_REQ-1:0][VSZ-1:0]                held_vc_q, held_vc_d;
    logic                                     error_q, error_d;

    logic [N_REQ-1:0]                req_flat, rel_flat, grant_flat;
    logic [N_REQ-1:0][PSZ-1:0]       port_flat;
    logic [N_REQ-1:0][VSZ-1:0]       vc_new_flat;
    logic [PORT_NUM-1:0][N_REQ-1:0]  cand, arb_gnt;
    logic [PORT_NUM-1:0]             port_free;
    logic [PORT_NUM-1:0][VSZ-1:0]    free_vc;

    // Requester r = in_port*VC_NUM + in_vc, matching the packed [port][vc] layout.
    assign req_flat  = request_i;
    assign rel_flat  = release_i;
    assign port_flat = out_port_i;

    always_comb begin
        cand      = '0;
        port_free = '0;
        free_vc   = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            port_free[o] = ~&busy_q[o];
            for (int v = VC_NUM - 1; v >= 0; v--) begin
                if (!busy_q[o][v]) begin
                    free_vc[o] = VSZ'(v);
                end
            end
            for (int r = 0; r < N_REQ; r++) begin
                cand[o][r] = req_flat[r] && (port_flat[r] == PSZ'(o)) && !held_q[r];
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
        round_robin_arbiter #(.N(N_REQ)) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .request_i (cand[o]),
            .enable_i  (port_free[o]),
            .grant_o   (arb_gnt[o])
        );
    end

    always_comb begin
        grant_flat  = '0;
        vc_new_flat = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (arb_gnt[o][r]) begin
                    grant_flat[r]  = 1'b1;
                    vc_new_flat[r] = free_vc[o];
                end
            end
        end
        grant_o  = rst_n ? grant_flat : '0;
        vc_new_o = rst_n ? vc_new_flat : '0;
    end

    // Releases only touch VCs busy in busy_q, grants only free ones, so they never collide.
    always_comb begin
        busy_d      = busy_q;
        owner_d     = owner_q;
        held_d      = held_q;
        held_port_d = held_port_q;
        held_vc_d   = held_vc_q;
        error_d     = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            if (rel_flat[r]) begin
                if (held_q[r]) begin
                    busy_d[held_port_q[r]][held_vc_q[r]] = 1'b0;
                    held_d[r] = 1'b0;
                end else begin
                    error_d = 1'b1;
                end
            end
            if (req_flat[r] && (held_q[r] || (port_flat[r] > PSZ'(PORT_NUM - 1)))) begin
                error_d = 1'b1;
            end
            if (grant_flat[r]) begin
                busy_d[port_flat[r]][vc_new_flat[r]]  = 1'b1;
                owner_d[port_flat[r]][vc_new_flat[r]] = RW'(r);
                held_d[r]      = 1'b1;
                held_port_d[r] = port_flat[r];
                held_vc_d[r]   = vc_new_flat[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            owner_q     <= '0;
            held_q      <= '0;
            held_port_q <= '0;
            held_vc_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            held_q      <= held_d;
            held_port_q <= held_port_d;
            held_vc_q   <= held_vc_d;
            error_q     <= error_d;
        end
    end

    assign error_o = error_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator: reset, grants, contention, release, errors
// and fairness; fairness expectations follow the VC_ALLOC_RR_EN setting.
module tb_vc_allocator;
    import noc_params::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic  [4:0][1:0]        request_r;
    port_t [4:0][1:0]        out_port_r;
    logic  [4:0][1:0]        release_r;
    logic  [4:0][1:0]        grant;
    logic  [4:0][1:0][0:0]   vc_new;
    logic                    error;

    int checks = 0;
    int errors = 0;

    vc_allocator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .request_i  (request_r),
        .out_port_i (out_port_r),
        .release_i  (release_r),
        .grant_o    (grant),
        .vc_new_o   (vc_new),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bitOf(input int p, input int v);
        return 32'(1) << (p * 2 + v);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle: inputs change 1ns after the rising edge and start idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        request_r  = '0;
        release_r  = '0;
        out_port_r = {10{LOCAL}};
    endtask

    task automatic setReq(input int p, input int v, input port_t port);
        request_r[p][v]  = 1'b1;
        out_port_r[p][v] = port;
    endtask

    task automatic setRel(input int p, input int v);
        release_r[p][v] = 1'b1;
    endtask

    initial begin
        int wp;
        rst_n      = 1'b0;
        request_r  = '1;
        release_r  = '0;
        out_port_r = {10{NORTH}};
        @(negedge clk);
        checkOutput("reset_grant", 32'(grant), 32'h0);
        checkOutput("reset_vc_new", 32'(vc_new), 32'h0);
        checkOutput("reset_error", 32'(error), 32'h0);

        applyStimulus();
        rst_n = 1'b1;
        setReq(0, 0, LOCAL); setReq(4, 1, NORTH); setReq(0, 1, SOUTH);
        setReq(1, 0, WEST);  setReq(1, 1, EAST);
        @(negedge clk);
        checkOutput("post_reset_grant", 32'(grant),
                    bitOf(0, 0) | bitOf(4, 1) | bitOf(0, 1) | bitOf(1, 0) | bitOf(1, 1));
        checkOutput("post_reset_vc0", 32'(vc_new), 32'h0);

        applyStimulus();
        setRel(0, 0); setRel(4, 1); setRel(0, 1); setRel(1, 0); setRel(1, 1);
        @(negedge clk);
        checkOutput("post_reset_release_grant", 32'(grant), 32'h0);
        checkOutput("post_reset_error", 32'(error), 32'h0);
        applyStimulus();
        @(negedge clk);
        checkOutput("valid_release_error", 32'(error), 32'h0);

        applyStimulus();
        setReq(3, 1, EAST);
        @(negedge clk);
        checkOutput("single_grant", 32'(grant), bitOf(3, 1));
        checkOutput("single_vc_new", 32'(vc_new), 32'h0);
        applyStimulus();
        setReq(4, 0, EAST);
        @(negedge clk);
        checkOutput("second_grant", 32'(grant), bitOf(4, 0));
        checkOutput("second_vc_new", 32'(vc_new), bitOf(4, 0));
        checkOutput("single_error", 32'(error), 32'h0);

        applyStimulus();
        setReq(0, 0, NORTH); setReq(1, 0, NORTH); setReq(2, 0, NORTH);
        @(negedge clk);
        checkOutput("contend_grant1", 32'(grant), bitOf(0, 0));
        checkOutput("contend_vc1", 32'(vc_new), 32'h0);
        applyStimulus();
        setReq(1, 0, NORTH); setReq(2, 0, NORTH);
        @(negedge clk);
        checkOutput("contend_grant2", 32'(grant), bitOf(1, 0));
        checkOutput("contend_vc2", 32'(vc_new), bitOf(1, 0));
        applyStimulus();
        setReq(2, 0, NORTH);
        @(negedge clk);
        checkOutput("contend_blocked", 32'(grant), 32'h0);
        checkOutput("contend_error", 32'(error), 32'h0);

        applyStimulus();
        setReq(2, 0, NORTH); setRel(0, 0);
        @(negedge clk);
        checkOutput("release_cycle_grant", 32'(grant), 32'h0);
        applyStimulus();
        setReq(2, 0, NORTH);
        @(negedge clk);
        checkOutput("after_release_grant", 32'(grant), bitOf(2, 0));
        checkOutput("after_release_vc", 32'(vc_new), 32'h0);
        checkOutput("release_error", 32'(error), 32'h0);

        applyStimulus();
        setRel(1, 0); setRel(2, 0); setRel(3, 1); setRel(4, 0);
        @(negedge clk);
        checkOutput("cleanup_grant", 32'(grant), 32'h0);
        applyStimulus();
        @(negedge clk);
        checkOutput("cleanup_error", 32'(error), 32'h0);

        applyStimulus();
        setRel(1, 1);
        @(negedge clk);
        checkOutput("bad_release_same_cycle", 32'(error), 32'h0);
        applyStimulus();
        @(negedge clk);
        checkOutput("bad_release_error", 32'(error), 32'h1);
        applyStimulus();
        @(negedge clk);
        checkOutput("bad_release_one_cycle", 32'(error), 32'h0);

        applyStimulus();
        setReq(3, 1, EAST);
        @(negedge clk);
        checkOutput("hold_first_grant", 32'(grant), bitOf(3, 1));
        checkOutput("hold_first_vc", 32'(vc_new), 32'h0);
        applyStimulus();
        setReq(3, 1, EAST);
        @(negedge clk);
        checkOutput("hold_no_regrant", 32'(grant), 32'h0);
        checkOutput("hold_error_pre", 32'(error), 32'h0);
        applyStimulus();
        @(negedge clk);
        checkOutput("hold_error", 32'(error), 32'h1);
        applyStimulus();
        setRel(3, 1);
        @(negedge clk);
        checkOutput("hold_release_error", 32'(error), 32'h0);

        applyStimulus();
        setReq(2, 1, port_t'(3'd6));
        @(negedge clk);
        checkOutput("bad_port_grant", 32'(grant), 32'h0);
        checkOutput("bad_port_error_pre", 32'(error), 32'h0);
        applyStimulus();
        @(negedge clk);
        checkOutput("bad_port_error", 32'(error), 32'h1);

        for (int round = 0; round < 4; round++) begin
`ifdef VC_ALLOC_RR_EN
            wp = (round % 2 == 0) ? 1 : 0;
`else
            wp = 0;
`endif
            applyStimulus();
            setReq(0, 0, LOCAL); setReq(1, 0, LOCAL);
            @(negedge clk);
            checkOutput($sformatf("fair_grant_r%0d", round), 32'(grant), bitOf(wp, 0));
            checkOutput($sformatf("fair_vc_r%0d", round), 32'(vc_new), 32'h0);
            applyStimulus();
            setRel(wp, 0);
            @(negedge clk);
            checkOutput($sformatf("fair_error_r%0d", round), 32'(error), 32'h0);
        end

        applyStimulus();
        @(negedge clk);
        checkOutput("final_error", 32'(error), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
